hash_out_serializer: RTL and testbench
======================================

# hash_out_serializer

Buffers completed SHA-256 digests from the hash core's output handshake and emits each one as a sequence of narrower words on a valid/ready stream. It sits between the hash core's `hash_data`/`hash_valid`/`hash_rdy` port and a narrow sink such as a register bus bridge or a UART/AXI-stream adapter. It generalises the fixed 256-bit hash output with four parameters: digest width, output width, buffer depth and word order. It adds last-beat marking and occupancy reporting.

## Interface
- `DIGEST_W`, default 256: digest width in bits. Must be a multiple of `OUT_W`.
- `OUT_W`, default 32: output word width in bits.
- `DEPTH`, default 2: number of whole digests buffered. Must be 1 or greater.
- `MSW_FIRST`, default 1: 1 means the most-significant word is sent first; 0 means the least-significant word is sent first.
- `BEATS` (localparam) = `DIGEST_W/OUT_W`.
- `clk`  in  1  the block's single clock. All logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hash_data`  in  DIGEST_W  digest from the hash core.
- `hash_valid`  in  1  `hash_data` is valid.
- `hash_rdy`  out  1  the block can accept a digest.
- `out_data`  out  OUT_W  current output word.
- `out_valid`  out  1  `out_data` is valid.
- `out_rdy`  in  1  the sink accepts the word.
- `out_last`  out  1  the current word is the final beat of its digest.
- `level`  out  $clog2(DEPTH+1)  number of digests held, including the one being emitted.

## Operation
- Storage: a circular buffer of `DEPTH` digest entries, with a write pointer, a read pointer, `level`, and a beat counter `beat` of width $clog2(BEATS), minimum 1.
- Accept: a digest is written when `hash_valid && hash_rdy` at a rising edge. The write pointer advances and wraps from DEPTH-1 to 0.
- `hash_rdy = (level != DEPTH)`. It depends only on registered state, never on `out_rdy`. When the buffer is full, a digest is not accepted even in the same cycle that the final beat drains.
- Emit: `out_valid = (level != 0)`.
  - With MSW_FIRST=1, `out_data` = entry[rd][DIGEST_W-1-beat*OUT_W -: OUT_W].
  - With MSW_FIRST=0, `out_data` = entry[rd][beat*OUT_W +: OUT_W].
- `out_last = out_valid && (beat == BEATS-1)`.
- Beat transfer is `out_valid && out_rdy`:
  - If `beat < BEATS-1`, `beat` increments.
  - Otherwise `beat` is set to 0, the read pointer advances and wraps, and the entry is freed.
- Level update: `level` increments on accept, decrements on final-beat transfer, and is unchanged when both happen in the same cycle (possible only when level < DEPTH).
- States are implicit: EMPTY (level=0), BUSY (0<level<DEPTH), FULL (level=DEPTH). `beat` is orthogonal to these states.
- Stream rule: while `out_valid && !out_rdy`, the values of `out_data`, `out_last` and `beat` are held.
- BEATS=1 (OUT_W=DIGEST_W): every beat has `out_last=1`, and `beat` stays 0.
- `hash_data` is captured only at the accept edge. Later changes to `hash_data` do not affect stored entries.

## Timing
- Reset while `rst_n` is low, taking effect immediately and asynchronously:
  - pointers=0, `beat`=0, `level`=0
  - `out_valid`=0, `out_last`=0, `hash_rdy`=1
  - `out_data` is don't-care; the bench checks it only when `out_valid`=1.
- `hash_valid` is ignored while `rst_n` is low.
- Latency: a digest accepted at edge N gives `out_valid`=1 in the cycle after edge N when the buffer was empty. There is no combinational path from `hash_valid` to `out_valid`.
- Throughput: one beat per cycle while `out_rdy`=1. A back-to-back digest is emitted with no bubble after the final beat of the previous digest.
- Reset mid-digest: all buffered data and any partial beat are discarded. After reset, the first beat emitted is beat 0 of the next digest accepted.
- No combinational path from `out_rdy` to `hash_rdy`.

## Test plan
- Reset: drive `rst_n`=0 mid-stream → `out_valid`=0, `level`=0, `hash_rdy`=1 within the same cycle. After release, the next accepted digest starts at beat 0.
- Single digest, defaults: accept 256'h00000007_00000006_…_00000000 with `out_rdy`=1 → 8 consecutive beats 7,6,…,0, `out_last` only on value 0, first beat one cycle after accept.
- Word order: MSW_FIRST=0 with the same digest → beats 0,1,…,7, `out_last` on value 7.
- Backpressure: toggle `out_rdy` 1010… → each word is held while stalled, no word is duplicated or lost, and 8 transfers complete in 16 cycles.
- Full/simultaneous: with DEPTH=2 and `out_rdy`=0, offer 3 digests → `level`=2, `hash_rdy`=0, third not accepted. Release `out_rdy` → third accepted only after `level` drops to 1; accept and final-beat in the same cycle leaves `level` unchanged.
- Wrap and width variants: 5 back-to-back digests with DEPTH=2 (pointer wrap, no bubble between digests); OUT_W=256 → one beat per digest with `out_last`=1; OUT_W=64 → 4 beats.

Source files
------------

// File: rtl/hash_out_serializer_if.sv
// Digest-in / word-out handshake bundle for hash_out_serializer.
// slave is the serializer's view, master is the view of whoever drives it.
interface hash_out_serializer_if #(
    parameter int DIGEST_W = 256,
    parameter int OUT_W    = 32,
    parameter int DEPTH    = 2
) ();
    localparam int LW = $clog2(DEPTH + 1);

    logic [DIGEST_W-1:0] hash_data;
    logic                hash_valid;
    logic                hash_rdy;
    logic [OUT_W-1:0]    out_data;
    logic                out_valid;
    logic                out_rdy;
    logic                out_last;
    logic [LW-1:0]       level;

    modport slave (
        input  hash_data, hash_valid, out_rdy,
        output hash_rdy, out_data, out_valid, out_last, level
    );

    modport master (
        output hash_data, hash_valid, out_rdy,
        input  hash_rdy, out_data, out_valid, out_last, level
    );
endinterface

// File: rtl/hash_out_serializer.sv
// Buffers whole digests in a small circular buffer and streams each one
// out as BEATS words of OUT_W bits, marking the final word with out_last.
//
// state | meaning
// EMPTY | level == 0, nothing to emit, hash_rdy = 1
// BUSY  | 0 < level < DEPTH, emitting and accepting
// FULL  | level == DEPTH, hash_rdy = 0 until the current digest drains
// The state is implied by level; beat tracks progress within the head entry.
module hash_out_serializer #(
    parameter int DIGEST_W  = 256,
    parameter int OUT_W     = 32,
    parameter int DEPTH     = 2,
    parameter int MSW_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hash_out_serializer_if.slave  bus
);
    localparam int BEATS = DIGEST_W / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic [DIGEST_W-1:0] mem_q [DEPTH];
    logic [DIGEST_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [LW-1:0]       level_q, level_d;

    logic                accept;
    logic                xfer;
    logic                last_beat;
    logic                pop;
    logic [DIGEST_W-1:0] rd_entry;
    logic [BW-1:0]       word_idx;

    // hash_rdy and out_valid come straight from level so neither side sees
    // a combinational path from the other side's handshake.
    assign bus.hash_rdy  = (level_q != LW'(DEPTH));
    assign bus.out_valid = (level_q != '0);
    assign bus.level     = level_q;

    assign last_beat    = (beat_q == BW'(BEATS - 1));
    assign bus.out_last = bus.out_valid && last_beat;

    assign accept = bus.hash_valid && bus.hash_rdy;
    assign xfer   = bus.out_valid && bus.out_rdy;
    assign pop    = xfer && last_beat;

    // Word index counted from the LSB end of the entry.
    assign rd_entry     = mem_q[rd_ptr_q];
    assign word_idx     = (MSW_FIRST != 0) ? (BW'(BEATS - 1) - beat_q) : beat_q;
    assign bus.out_data = OUT_W'(rd_entry >> (word_idx * OUT_W));

    // Next-state for buffer storage, pointers, beat counter and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        level_d  = level_q;

        if (accept) begin
            mem_d[wr_ptr_q] = bus.hash_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end

        if (xfer) begin
            if (last_beat) begin
                beat_d   = '0;
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        case ({accept, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // State registers; reset discards every buffered digest and partial beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
            level_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: tb/tb_hash_out_serializer.sv
// Scoreboard bench for hash_out_serializer: four instances cover the default
// configuration, LSW-first order, a single 256-bit beat and 64-bit beats.
module tb_hash_out_serializer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hash_out_serializer_if #(.DIGEST_W(256), .OUT_W(32),  .DEPTH(2)) if0 ();
    hash_out_serializer_if #(.DIGEST_W(256), .OUT_W(32),  .DEPTH(2)) if1 ();
    hash_out_serializer_if #(.DIGEST_W(256), .OUT_W(256), .DEPTH(2)) if2 ();
    hash_out_serializer_if #(.DIGEST_W(256), .OUT_W(64),  .DEPTH(2)) if3 ();

    hash_out_serializer #(.DIGEST_W(256), .OUT_W(32), .DEPTH(2), .MSW_FIRST(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    hash_out_serializer #(.DIGEST_W(256), .OUT_W(32), .DEPTH(2), .MSW_FIRST(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    hash_out_serializer #(.DIGEST_W(256), .OUT_W(256), .DEPTH(2), .MSW_FIRST(1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    hash_out_serializer #(.DIGEST_W(256), .OUT_W(64), .DEPTH(2), .MSW_FIRST(1))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    typedef struct {
        logic [255:0] data;
        logic         last;
    } beat_t;

    beat_t        sbq[$];
    logic [255:0] pend[$];
    int           tests_run = 0;
    int           fails = 0;

    localparam logic [255:0] SPEC_DG = {32'd7, 32'd6, 32'd5, 32'd4,
                                        32'd3, 32'd2, 32'd1, 32'd0};

    function automatic int beats_of(int idx);
        case (idx)
            2:       return 1;
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [255:0] rand_dg();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // Expected words of one digest, in emission order, onto the scoreboard.
    task automatic push_exp(input int idx, input logic [255:0] dg);
        int b;
        int w;
        int wi;
        logic [255:0] mask;
        beat_t e;
        b = beats_of(idx);
        w = 256 / b;
        mask = (w == 256) ? {256{1'b1}} : ((256'(1) << w) - 256'(1));
        for (int k = 0; k < b; k++) begin
            wi = (idx == 1) ? k : (b - 1 - k);
            e.data = (dg >> (wi * w)) & mask;
            e.last = (k == b - 1);
            sbq.push_back(e);
        end
    endtask

    // Digests still held: one per not-yet-transferred final beat.
    function automatic int sb_level();
        int n = 0;
        foreach (sbq[i]) if (sbq[i].last) n++;
        return n;
    endfunction

    task automatic set_in(input int idx, input logic hv, input logic [255:0] hd, input logic ordy);
        case (idx)
            0: begin if0.hash_valid = hv; if0.hash_data = hd; if0.out_rdy = ordy; end
            1: begin if1.hash_valid = hv; if1.hash_data = hd; if1.out_rdy = ordy; end
            2: begin if2.hash_valid = hv; if2.hash_data = hd; if2.out_rdy = ordy; end
            default: begin if3.hash_valid = hv; if3.hash_data = hd; if3.out_rdy = ordy; end
        endcase
    endtask

    task automatic get_obs(input int idx, output logic ov, output logic [255:0] od,
                           output logic ol, output logic hr, output logic [1:0] lv);
        case (idx)
            0: begin ov = if0.out_valid; od = 256'(if0.out_data); ol = if0.out_last; hr = if0.hash_rdy; lv = if0.level; end
            1: begin ov = if1.out_valid; od = 256'(if1.out_data); ol = if1.out_last; hr = if1.hash_rdy; lv = if1.level; end
            2: begin ov = if2.out_valid; od = if2.out_data;       ol = if2.out_last; hr = if2.hash_rdy; lv = if2.level; end
            default: begin ov = if3.out_valid; od = 256'(if3.out_data); ol = if3.out_last; hr = if3.hash_rdy; lv = if3.level; end
        endcase
    endtask

    task automatic test_reset();
        logic ov, ol, hr, hv;
        logic [255:0] od;
        logic [1:0] lv;
        int xf = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) set_in(i, 1'b1, rand_dg(), 1'b1);
        #1;
        for (int i = 0; i < 4; i++) begin
            get_obs(i, ov, od, ol, hr, lv);
            tests_run++;
            if (ov !== 1'b0 || ol !== 1'b0 || hr !== 1'b1 || lv !== 2'd0) begin
                fails++;
                $display("FAIL reset_poweron dut%0d valid=%b last=%b rdy=%b level=%0d, required 0 0 1 0", i, ov, ol, hr, lv);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) set_in(i, 1'b0, '0, 1'b1);
        rst_n = 1'b1;

        sbq.delete();
        pend.delete();
        pend.push_back(rand_dg());
        pend.push_back(rand_dg());
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 5) begin
                rst_n = 1'b0;
                #1;
            end
            if (c == 7) begin
                rst_n = 1'b1;
                sbq.delete();
                pend.delete();
                pend.push_back(SPEC_DG);
                xf = 0;
            end
            get_obs(0, ov, od, ol, hr, lv);
            if (!rst_n) begin
                tests_run++;
                if (ov !== 1'b0 || ol !== 1'b0 || hr !== 1'b1 || lv !== 2'd0) begin
                    fails++;
                    $display("FAIL reset_midstream c=%0d valid=%b last=%b rdy=%b level=%0d, required 0 0 1 0", c, ov, ol, hr, lv);
                end
                set_in(0, 1'b1, rand_dg(), 1'b1);
                continue;
            end
            tests_run++;
            if (ov !== (sbq.size() != 0) || (ov !== 1'b1 && ol !== 1'b0) ||
                hr !== (sb_level() != 2) || lv !== 2'(sb_level())) begin
                fails++;
                $display("FAIL reset_flags c=%0d valid=%b last=%b rdy=%b level=%0d, required valid=%b level=%0d",
                         c, ov, ol, hr, lv, sbq.size() != 0, sb_level());
            end
            if (ov === 1'b1 && sbq.size() != 0) begin
                tests_run++;
                if (od !== sbq[0].data || ol !== sbq[0].last) begin
                    fails++;
                    $display("FAIL reset_data c=%0d got %h last=%b, required %h last=%b", c, od, ol, sbq[0].data, sbq[0].last);
                end
            end
            hv = (pend.size() != 0);
            set_in(0, hv, hv ? pend[0] : 256'(0), 1'b1);
            if (ov === 1'b1 && sbq.size() != 0) begin sbq.pop_front(); xf++; end
            if (hv && hr === 1'b1) push_exp(0, pend.pop_front());
        end
        tests_run++;
        if (xf !== 8 || sbq.size() != 0) begin
            fails++;
            $display("FAIL reset_after transfers=%0d left=%0d, required 8 and 0", xf, sbq.size());
        end
    endtask

    task automatic test_single();
        logic ov, ol, hr, hv;
        logic [255:0] od;
        logic [1:0] lv;
        int first_valid = -1;
        int xf = 0;
        int exp_val;
        sbq.delete();
        pend.delete();
        pend.push_back(SPEC_DG);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            get_obs(0, ov, od, ol, hr, lv);
            tests_run++;
            if (ov !== (sbq.size() != 0) || (ov !== 1'b1 && ol !== 1'b0) ||
                hr !== (sb_level() != 2) || lv !== 2'(sb_level())) begin
                fails++;
                $display("FAIL single_flags c=%0d valid=%b last=%b rdy=%b level=%0d, required valid=%b level=%0d",
                         c, ov, ol, hr, lv, sbq.size() != 0, sb_level());
            end
            if (ov === 1'b1 && sbq.size() != 0) begin
                if (first_valid < 0) first_valid = c;
                exp_val = 7 - xf;
                tests_run++;
                if (od !== sbq[0].data || ol !== sbq[0].last || od !== 256'(exp_val) || ol !== (exp_val == 0)) begin
                    fails++;
                    $display("FAIL single_data c=%0d got %h last=%b, required %0d last=%b", c, od, ol, exp_val, exp_val == 0);
                end
            end
            hv = (pend.size() != 0);
            set_in(0, hv, hv ? pend[0] : 256'(0), 1'b1);
            if (ov === 1'b1 && sbq.size() != 0) begin sbq.pop_front(); xf++; end
            if (hv && hr === 1'b1) push_exp(0, pend.pop_front());
        end
        tests_run++;
        if (first_valid !== 1 || xf !== 8) begin
            fails++;
            $display("FAIL single_latency first_valid_cycle=%0d transfers=%0d, required 1 and 8", first_valid, xf);
        end
    endtask

    task automatic test_backpressure();
        logic ov, ol, hr, hv, ordy;
        logic [255:0] od;
        logic [1:0] lv;
        int xf = 0;
        int last_xf = -1;
        sbq.delete();
        pend.delete();
        pend.push_back(rand_dg());
        for (int c = 0; c < 17; c++) begin
            @(posedge clk); #1;
            get_obs(0, ov, od, ol, hr, lv);
            tests_run++;
            if (ov !== (sbq.size() != 0) || (ov !== 1'b1 && ol !== 1'b0) ||
                hr !== (sb_level() != 2) || lv !== 2'(sb_level())) begin
                fails++;
                $display("FAIL bp_flags c=%0d valid=%b last=%b rdy=%b level=%0d, required valid=%b level=%0d",
                         c, ov, ol, hr, lv, sbq.size() != 0, sb_level());
            end
            if (ov === 1'b1 && sbq.size() != 0) begin
                tests_run++;
                if (od !== sbq[0].data || ol !== sbq[0].last) begin
                    fails++;
                    $display("FAIL bp_data c=%0d got %h last=%b, required %h last=%b", c, od, ol, sbq[0].data, sbq[0].last);
                end
            end
            ordy = (c % 2 == 1);
            hv = (pend.size() != 0);
            set_in(0, hv, hv ? pend[0] : 256'(0), ordy);
            if (ov === 1'b1 && ordy && sbq.size() != 0) begin sbq.pop_front(); xf++; last_xf = c; end
            if (hv && hr === 1'b1) push_exp(0, pend.pop_front());
        end
        set_in(0, 1'b0, '0, 1'b1);
        tests_run++;
        if (xf !== 8 || last_xf !== 15) begin
            fails++;
            $display("FAIL bp_count transfers=%0d last_cycle=%0d, required 8 and 15", xf, last_xf);
        end
    endtask

    task automatic test_full();
        logic ov, ol, hr, hv, ordy;
        logic [255:0] od;
        logic [1:0] lv;
        int n_acc = 0;
        int acc3 = -1;
        int acc4 = -1;
        sbq.delete();
        pend.delete();
        for (int i = 0; i < 3; i++) pend.push_back(rand_dg());
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            get_obs(0, ov, od, ol, hr, lv);
            tests_run++;
            if (ov !== (sbq.size() != 0) || (ov !== 1'b1 && ol !== 1'b0) ||
                hr !== (sb_level() != 2) || lv !== 2'(sb_level())) begin
                fails++;
                $display("FAIL full_flags c=%0d valid=%b last=%b rdy=%b level=%0d, required valid=%b level=%0d",
                         c, ov, ol, hr, lv, sbq.size() != 0, sb_level());
            end
            if (ov === 1'b1 && sbq.size() != 0) begin
                tests_run++;
                if (od !== sbq[0].data || ol !== sbq[0].last) begin
                    fails++;
                    $display("FAIL full_data c=%0d got %h last=%b, required %h last=%b", c, od, ol, sbq[0].data, sbq[0].last);
                end
            end
            if (c == 29) pend.push_back(rand_dg());
            ordy = (c >= 6);
            hv = (pend.size() != 0);
            set_in(0, hv, hv ? pend[0] : 256'(0), ordy);
            if (ov === 1'b1 && ordy && sbq.size() != 0) sbq.pop_front();
            if (hv && hr === 1'b1) begin
                push_exp(0, pend.pop_front());
                n_acc++;
                if (n_acc == 3) acc3 = c;
                if (n_acc == 4) acc4 = c;
            end
        end
        tests_run++;
        if (acc3 !== 14 || acc4 !== 29) begin
            fails++;
            $display("FAIL full_accept third_at=%0d fourth_at=%0d, required 14 and 29", acc3, acc4);
        end
    endtask

    task automatic test_wrap();
        logic ov, ol, hr, hv;
        logic [255:0] od;
        logic [1:0] lv;
        int xf = 0;
        int first_xf = -1;
        int last_xf = -1;
        sbq.delete();
        pend.delete();
        for (int i = 0; i < 5; i++) pend.push_back(rand_dg());
        for (int c = 0; c < 44; c++) begin
            @(posedge clk); #1;
            get_obs(0, ov, od, ol, hr, lv);
            tests_run++;
            if (ov !== (sbq.size() != 0) || (ov !== 1'b1 && ol !== 1'b0) ||
                hr !== (sb_level() != 2) || lv !== 2'(sb_level())) begin
                fails++;
                $display("FAIL wrap_flags c=%0d valid=%b last=%b rdy=%b level=%0d, required valid=%b level=%0d",
                         c, ov, ol, hr, lv, sbq.size() != 0, sb_level());
            end
            if (ov === 1'b1 && sbq.size() != 0) begin
                tests_run++;
                if (od !== sbq[0].data || ol !== sbq[0].last) begin
                    fails++;
                    $display("FAIL wrap_data c=%0d got %h last=%b, required %h last=%b", c, od, ol, sbq[0].data, sbq[0].last);
                end
            end
            hv = (pend.size() != 0);
            set_in(0, hv, hv ? pend[0] : 256'(0), 1'b1);
            if (ov === 1'b1 && sbq.size() != 0) begin
                sbq.pop_front();
                xf++;
                if (first_xf < 0) first_xf = c;
                last_xf = c;
            end
            if (hv && hr === 1'b1) push_exp(0, pend.pop_front());
        end
        tests_run++;
        if (xf !== 40 || first_xf !== 1 || last_xf !== 40) begin
            fails++;
            $display("FAIL wrap_count transfers=%0d first=%0d last=%0d, required 40 1 40", xf, first_xf, last_xf);
        end
    endtask

    task automatic test_variants();
        logic ov, ol, hr, hv;
        logic [255:0] od;
        logic [1:0] lv;
        int xf;
        for (int idx = 1; idx < 4; idx++) begin
            xf = 0;
            sbq.delete();
            pend.delete();
            pend.push_back(SPEC_DG);
            pend.push_back(rand_dg());
            for (int c = 0; c < 2 * beats_of(idx) + 4; c++) begin
                @(posedge clk); #1;
                get_obs(idx, ov, od, ol, hr, lv);
                tests_run++;
                if (ov !== (sbq.size() != 0) || (ov !== 1'b1 && ol !== 1'b0) ||
                    hr !== (sb_level() != 2) || lv !== 2'(sb_level())) begin
                    fails++;
                    $display("FAIL variant%0d_flags c=%0d valid=%b last=%b rdy=%b level=%0d, required valid=%b level=%0d",
                             idx, c, ov, ol, hr, lv, sbq.size() != 0, sb_level());
                end
                if (ov === 1'b1 && sbq.size() != 0) begin
                    tests_run++;
                    if (od !== sbq[0].data || ol !== sbq[0].last) begin
                        fails++;
                        $display("FAIL variant%0d_data c=%0d got %h last=%b, required %h last=%b",
                                 idx, c, od, ol, sbq[0].data, sbq[0].last);
                    end
                end
                hv = (pend.size() != 0);
                set_in(idx, hv, hv ? pend[0] : 256'(0), 1'b1);
                if (ov === 1'b1 && sbq.size() != 0) begin sbq.pop_front(); xf++; end
                if (hv && hr === 1'b1) push_exp(idx, pend.pop_front());
            end
            tests_run++;
            if (xf !== 2 * beats_of(idx)) begin
                fails++;
                $display("FAIL variant%0d_count transfers=%0d, required %0d", idx, xf, 2 * beats_of(idx));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full();
        test_wrap();
        test_variants();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
